ctrl_pipe_unit: RTL and testbench
=================================

// Module: ctrl_pipe_unit
// PURPOSE
//  Registered ARM-subset control unit: decodes IR in ID and carries the control word down EX->MEM->WB.
//  Adds condition-field evaluation, load-use stall, branch flush, external freeze and a bubble counter.
//  Sits between the IF/ID instruction register and the datapath stage muxes; replaces purely combinational decode.
// PARAMETERS
//  REG_W    4   register-index width (Rn=IR[19:16], Rd=IR[15:12], Rm=IR[3:0])
//  CNT_W    16  width of saturating bubble counter
//  COND_EN  1   1: evaluate IR[31:28] vs flags; 0: every instruction executes
//  HAZ_EN   1   1: load-use detection active; 0: id_stall tied 0
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      synchronous, active-high
//  ir           in   32     instruction in ID
//  ir_valid     in   1      ir holds a real instruction
//  flags        in   4      {N,Z,C,V} from status register
//  ex_flush     in   1      branch resolved taken in EX: squash ID and EX
//  stall_ext    in   1      memory busy: freeze all stages
//  id_stall     out  1      hold PC and IF/ID (combinational)
//  ex_op        out  4      ALU opcode;  ex_sm/ex_mm out 2 each: shifter / memory-size mode
//  ex_ctl       out  7      {load,b,rf,rw,data,shift_imm,valid}
//  ex_rd        out  REG_W  destination index in EX
//  mem_ctl      out  5      {load,rf,rw,data,valid};  mem_mm out 2;  mem_rd out REG_W
//  wb_ctl       out  3      {load,rf,valid};  wb_rd out REG_W
//  bubble_cnt   out  CNT_W  bubbles inserted since reset, saturating
// BEHAVIOUR
//  Decode (combinational, ID): all-zero IR = NOP (all control 0).
//   IR[27:26]=00 data-proc: op=IR[24:21], rf=1, mm=00; IR[25]=1 -> sm=00,shift_imm=1;
//    IR[25]=0 -> sm=01, shift_imm=(IR[11:4]!=0).
//   IR[27:26]=01 load/store: op=0100 if U(IR[23]) else 0010; sm=10; mm=10 word / 00 byte (IR[22]);
//    data=1; L(IR[20])=1 -> load=1,rf=1,rw=0; L=0 -> rw=1,rf=0;
//    shift_imm = IR[25] ? (IR[11:4]!=0) : 1.  sm is 10 for every load/store form.
//   IR[27:25]=101 branch: b=1, all else 0.  Other encodings: all control 0.
//  Condition: COND_EN=1 and cond fails (EQ..LE per ARM; 1110 always; 1111 never) -> word becomes bubble.
//  Bubble = all control bits 0, rd=0, valid=0.
//  Load-use (HAZ_EN=1): id_stall=1 when ex_ctl.load & ex_ctl.valid & ir_valid & ex_rd matches
//   Rn (data-proc except MOV/MVN, all load/store), Rm (IR[25]=0 data-proc, IR[25]=1 load/store)
//   or Rd (store). Stall cycle: EX loads bubble, ID holds.
//  Stage update each clk, priority high->low:
//   1 reset: all stage regs bubble, bubble_cnt=0, id_stall=0.
//   2 stall_ext: EX/MEM/WB hold; id_stall forced 1; counter holds.
//   3 ex_flush: EX <= bubble (ID squashed), MEM <= old EX, WB <= old MEM; id_stall ignored.
//   4 id_stall: EX <= bubble, MEM/WB advance.
//   5 else: EX <= decoded ID word (or bubble if !ir_valid / cond fail), MEM/WB advance.
//  bubble_cnt +1 on any cycle cases 3 or 4 apply, or case 5 inserts a cond-fail bubble; saturates at all-ones.
//  Latency: ID decode -> ex_* 1 cycle, mem_* 2, wb_* 3. Flush+stall same cycle: flush wins, single bubble counted.
//  Reset mid-operation: all in-flight words dropped next edge; no partial state survives.
// STRUCTURE
//  Shared package ctrl_pkg: opcode constants (ADD=0100, SUB=0010), sm/mm encodings,
//   cond codes, control-word field positions, bubble constant.
//  Sub-module ctrl_decode: pure combinational IR->control word (decode table above); top holds
//   cond check, hazard compare, stage registers and counter.
// TESTING
//  reset asserted 2 cycles with ir=E0810002 -> all outputs 0, bubble_cnt=0, id_stall=0.
//  ADD r0,r1,r2 (E0810002) -> ex_op=0100, ex_sm=01, rf=1 next cycle; mem_ctl rf=1 at +2; wb_rd=0 at +3.
//  LDR r3,[r1] (E5913000) then ADD r4,r3,r5 (E0834005) -> id_stall=1 one cycle, bubble_cnt=1, ADD in EX a cycle later.
//  flags Z=0, ir=00810002 (ADDEQ) -> ex_ctl.valid=0, bubble_cnt+1; Z=1 -> executes, ex_op=0100.
//  ex_flush with id_stall same cycle -> EX bubble, MEM gets prior EX, bubble_cnt +1 only.
//  stall_ext high 3 cycles mid-stream -> ex/mem/wb unchanged, id_stall=1; CNT_W=2 run 5 bubbles -> saturates at 3.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the pipelined control unit: opcodes, shifter/memory
// modes, condition codes and the per-stage control-word layouts.
package ctrl_pkg;

   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_MOV = 4'b1101;
   localparam logic [3:0] OP_MVN = 4'b1111;

   localparam logic [1:0] SM_IMM = 2'b00;
   localparam logic [1:0] SM_REG = 2'b01;
   localparam logic [1:0] SM_LS  = 2'b10;

   localparam logic [1:0] MM_BYTE = 2'b00;
   localparam logic [1:0] MM_WORD = 2'b10;

   typedef enum logic [3:0] {
      COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
      COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
      COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
      COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
   } cond_e;

   // Field order matches the ex_ctl / mem_ctl / wb_ctl output vectors MSB first.
   typedef struct packed {
      logic load;
      logic b;
      logic rf;
      logic rw;
      logic data;
      logic shift_imm;
      logic valid;
   } ctl_t;

   typedef struct packed {
      logic load;
      logic rf;
      logic rw;
      logic data;
      logic valid;
   } mem_ctl_t;

   typedef struct packed {
      logic load;
      logic rf;
      logic valid;
   } wb_ctl_t;

   typedef struct packed {
      ctl_t       ctl;
      logic [3:0] op;
      logic [1:0] sm;
      logic [1:0] mm;
   } word_t;

   localparam word_t WORD_BUBBLE = '0;

   // flags = {N,Z,C,V}
   function automatic logic cond_pass(input cond_e cond, input logic [3:0] flags);
      logic n, z, c, v, ok;
      {n, z, c, v} = flags;
      case (cond)
         COND_EQ: ok = z;
         COND_NE: ok = !z;
         COND_CS: ok = c;
         COND_CC: ok = !c;
         COND_MI: ok = n;
         COND_PL: ok = !n;
         COND_VS: ok = v;
         COND_VC: ok = !v;
         COND_HI: ok = c && !z;
         COND_LS: ok = !c || z;
         COND_GE: ok = (n == v);
         COND_LT: ok = (n != v);
         COND_GT: ok = !z && (n == v);
         COND_LE: ok = z || (n != v);
         COND_AL: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/ctrl_pipe_unit_decode.sv
// Combinational IR -> control-word decode for the ID stage, plus flags saying which
// register fields the instruction reads (consumed by the load-use compare in the top).
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [31:0] ir,
   output word_t       word,
   output logic        rd_en,
   output logic        use_rn,
   output logic        use_rm,
   output logic        use_rd
);

   always_comb begin
      word   = WORD_BUBBLE;
      rd_en  = 1'b0;
      use_rn = 1'b0;
      use_rm = 1'b0;
      use_rd = 1'b0;
      // All-zero IR is a true NOP: no control, no register reads.
      if (ir != '0) begin
         word.ctl.valid = 1'b1;
         if (ir[27:26] == 2'b00) begin
            word.op     = ir[24:21];
            word.ctl.rf = 1'b1;
            word.mm     = MM_BYTE;
            if (ir[25]) begin
               word.sm            = SM_IMM;
               word.ctl.shift_imm = 1'b1;
            end else begin
               word.sm            = SM_REG;
               word.ctl.shift_imm = (ir[11:4] != '0);
            end
            rd_en  = 1'b1;
            use_rn = (ir[24:21] != OP_MOV) && (ir[24:21] != OP_MVN);
            use_rm = !ir[25];
         end else if (ir[27:26] == 2'b01) begin
            word.op            = ir[23] ? OP_ADD : OP_SUB;
            word.sm            = SM_LS;
            word.mm            = ir[22] ? MM_BYTE : MM_WORD;
            word.ctl.data      = 1'b1;
            word.ctl.load      = ir[20];
            word.ctl.rf        = ir[20];
            word.ctl.rw        = !ir[20];
            word.ctl.shift_imm = ir[25] ? (ir[11:4] != '0) : 1'b1;
            rd_en  = 1'b1;
            use_rn = 1'b1;
            use_rm = ir[25];
            use_rd = !ir[20];
         end else if (ir[27:25] == 3'b101) begin
            word.ctl.b = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Registered control pipeline: decodes IR in ID and carries the control word through
// EX/MEM/WB with condition squash, load-use stall, branch flush, freeze and bubble count.
module ctrl_pipe_unit
   import ctrl_pkg::*;
#(
   parameter int unsigned REG_W   = 4,
   parameter int unsigned CNT_W   = 16,
   parameter bit          COND_EN = 1'b1,
   parameter bit          HAZ_EN  = 1'b1
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      ir,
   input  logic             ir_valid,
   input  logic [3:0]       flags,
   input  logic             ex_flush,
   input  logic             stall_ext,
   output logic             id_stall,
   output logic [3:0]       ex_op,
   output logic [1:0]       ex_sm,
   output logic [1:0]       ex_mm,
   output logic [6:0]       ex_ctl,
   output logic [REG_W-1:0] ex_rd,
   output logic [4:0]       mem_ctl,
   output logic [1:0]       mem_mm,
   output logic [REG_W-1:0] mem_rd,
   output logic [2:0]       wb_ctl,
   output logic [REG_W-1:0] wb_rd,
   output logic [CNT_W-1:0] bubble_cnt
);

   word_t            dec;
   logic             rd_en, use_rn, use_rm, use_rd;

   word_t            ex_q, ex_d;
   logic [REG_W-1:0] ex_rd_q, ex_rd_d;
   mem_ctl_t         mem_q;
   logic [1:0]       mem_mm_q;
   logic [REG_W-1:0] mem_rd_q;
   wb_ctl_t          wb_q;
   logic [REG_W-1:0] wb_rd_q;
   logic [CNT_W-1:0] cnt_q;

   logic             cond_ok, cond_fail, haz, bump;

   ctrl_decode u_decode (
      .ir     (ir),
      .word   (dec),
      .rd_en  (rd_en),
      .use_rn (use_rn),
      .use_rm (use_rm),
      .use_rd (use_rd)
   );

   always_comb begin
      haz = 1'b0;
      if (HAZ_EN && ex_q.ctl.load && ex_q.ctl.valid && ir_valid) begin
         haz = (use_rn && (ex_rd_q == ir[16 +: REG_W])) ||
               (use_rm && (ex_rd_q == ir[0  +: REG_W])) ||
               (use_rd && (ex_rd_q == ir[12 +: REG_W]));
      end
      id_stall = !reset && (stall_ext || haz);
   end

   always_comb begin
      cond_ok   = !COND_EN || cond_pass(cond_e'(ir[31:28]), flags);
      cond_fail = ir_valid && dec.ctl.valid && !cond_ok;
      ex_d      = WORD_BUBBLE;
      ex_rd_d   = '0;
      bump      = 1'b0;
      // Flush outranks the load-use stall; either way EX takes exactly one bubble.
      if (ex_flush || haz) begin
         bump = 1'b1;
      end else if (ir_valid && cond_ok) begin
         ex_d    = dec;
         ex_rd_d = rd_en ? ir[12 +: REG_W] : '0;
      end else begin
         bump = cond_fail;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q     <= WORD_BUBBLE;
         ex_rd_q  <= '0;
         mem_q    <= '0;
         mem_mm_q <= '0;
         mem_rd_q <= '0;
         wb_q     <= '0;
         wb_rd_q  <= '0;
         cnt_q    <= '0;
      end else if (!stall_ext) begin
         ex_q     <= ex_d;
         ex_rd_q  <= ex_rd_d;
         mem_q    <= '{load: ex_q.ctl.load, rf: ex_q.ctl.rf, rw: ex_q.ctl.rw,
                       data: ex_q.ctl.data, valid: ex_q.ctl.valid};
         mem_mm_q <= ex_q.mm;
         mem_rd_q <= ex_rd_q;
         wb_q     <= '{load: mem_q.load, rf: mem_q.rf, valid: mem_q.valid};
         wb_rd_q  <= mem_rd_q;
         if (bump && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      ex_op      = ex_q.op;
      ex_sm      = ex_q.sm;
      ex_mm      = ex_q.mm;
      ex_ctl     = ex_q.ctl;
      ex_rd      = ex_rd_q;
      mem_ctl    = mem_q;
      mem_mm     = mem_mm_q;
      mem_rd     = mem_rd_q;
      wb_ctl     = wb_q;
      wb_rd      = wb_rd_q;
      bubble_cnt = cnt_q;
   end

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit: a stage-by-stage reference model checked every
// cycle, plus literal expectations at the key points; a CNT_W=2 copy checks saturation.
module tb_ctrl_pipe_unit;

   logic        clk, reset, ir_valid, ex_flush, stall_ext;
   logic [31:0] ir;
   logic [3:0]  flags;

   logic        id_stall, id_stall2;
   logic [3:0]  ex_op, ex_op2;
   logic [1:0]  ex_sm, ex_sm2, ex_mm, ex_mm2, mem_mm, mem_mm2;
   logic [6:0]  ex_ctl, ex_ctl2;
   logic [3:0]  ex_rd, ex_rd2, mem_rd, mem_rd2, wb_rd, wb_rd2;
   logic [4:0]  mem_ctl, mem_ctl2;
   logic [2:0]  wb_ctl, wb_ctl2;
   logic [15:0] bubble_cnt;
   logic [1:0]  bubble_cnt2;

   ctrl_pipe_unit dut (
      .clk(clk), .reset(reset), .ir(ir), .ir_valid(ir_valid), .flags(flags),
      .ex_flush(ex_flush), .stall_ext(stall_ext), .id_stall(id_stall),
      .ex_op(ex_op), .ex_sm(ex_sm), .ex_mm(ex_mm), .ex_ctl(ex_ctl), .ex_rd(ex_rd),
      .mem_ctl(mem_ctl), .mem_mm(mem_mm), .mem_rd(mem_rd),
      .wb_ctl(wb_ctl), .wb_rd(wb_rd), .bubble_cnt(bubble_cnt)
   );

   ctrl_pipe_unit #(.CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .ir(ir), .ir_valid(ir_valid), .flags(flags),
      .ex_flush(ex_flush), .stall_ext(stall_ext), .id_stall(id_stall2),
      .ex_op(ex_op2), .ex_sm(ex_sm2), .ex_mm(ex_mm2), .ex_ctl(ex_ctl2), .ex_rd(ex_rd2),
      .mem_ctl(mem_ctl2), .mem_mm(mem_mm2), .mem_rd(mem_rd2),
      .wb_ctl(wb_ctl2), .wb_rd(wb_rd2), .bubble_cnt(bubble_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      bit       load, b, rf, rw, data, shimm, valid;
      bit [3:0] op;
      bit [1:0] sm, mm;
      bit [3:0] rd;
   } mw_t;

   mw_t m_ex, m_mem, m_wb;
   int  m_cnt;
   bit  chk = 1'b0;

   function automatic mw_t md(input logic [31:0] w);
      mw_t r;
      r = '0;
      if (w == 32'h0) return r;
      r.valid = 1;
      if (w[27:26] == 2'b00) begin
         r.rf = 1; r.op = w[24:21]; r.rd = w[15:12]; r.mm = 2'b00;
         r.sm    = w[25] ? 2'b00 : 2'b01;
         r.shimm = w[25] ? 1'b1 : (w[11:4] != 8'h0);
      end else if (w[27:26] == 2'b01) begin
         r.op = w[23] ? 4'd4 : 4'd2; r.sm = 2'b10; r.mm = w[22] ? 2'b00 : 2'b10;
         r.data = 1; r.rd = w[15:12];
         if (w[20]) begin r.load = 1; r.rf = 1; end else r.rw = 1;
         r.shimm = w[25] ? (w[11:4] != 8'h0) : 1'b1;
      end else if (w[27:25] == 3'b101) begin
         r.b = 1;
      end
      return r;
   endfunction

   function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         4'd0:  return z;          4'd1:  return !z;
         4'd2:  return cy;         4'd3:  return !cy;
         4'd4:  return n;          4'd5:  return !n;
         4'd6:  return v;          4'd7:  return !v;
         4'd8:  return cy && !z;   4'd9:  return !cy || z;
         4'd10: return n == v;     4'd11: return n != v;
         4'd12: return !z && n == v;
         4'd13: return z || n != v;
         4'd14: return 1;
         default: return 0;
      endcase
   endfunction

   // Registers an instruction reads; an all-zero NOP reads nothing.
   function automatic bit m_hz(input logic [31:0] w, input logic v, input mw_t e);
      bit [3:0] rn, rm, rdf;
      if (!(e.load && e.valid && v) || w == 32'h0) return 0;
      rn = w[19:16]; rm = w[3:0]; rdf = w[15:12];
      if (w[27:26] == 2'b00)
         return ((w[24:21] != 4'd13 && w[24:21] != 4'd15 && rn == e.rd) ||
                 (!w[25] && rm == e.rd));
      if (w[27:26] == 2'b01)
         return (rn == e.rd) || (w[25] && rm == e.rd) || (!w[20] && rdf == e.rd);
      return 0;
   endfunction

   always @(posedge clk) begin
      bit  hz;
      mw_t d;
      hz = m_hz(ir, ir_valid, m_ex);
      d  = md(ir);
      if (reset) begin
         m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0; chk = 1'b1;
      end else if (!stall_ext) begin
         m_wb  = m_mem;
         m_mem = m_ex;
         if (ex_flush || hz) begin
            m_ex = '0; m_cnt++;
         end else if (ir_valid && d.valid && m_cond(ir[31:28], flags)) begin
            m_ex = d;
         end else begin
            m_ex = '0;
            if (ir_valid && d.valid) m_cnt++;
         end
      end
   end

   always @(negedge clk) begin
      if (chk) begin
         check("ex_op",   32'(ex_op),   32'(m_ex.op));
         check("ex_sm",   32'(ex_sm),   32'(m_ex.sm));
         check("ex_mm",   32'(ex_mm),   32'(m_ex.mm));
         check("ex_ctl",  32'(ex_ctl),
               32'({m_ex.load, m_ex.b, m_ex.rf, m_ex.rw, m_ex.data, m_ex.shimm, m_ex.valid}));
         check("ex_rd",   32'(ex_rd),   32'(m_ex.rd));
         check("mem_ctl", 32'(mem_ctl),
               32'({m_mem.load, m_mem.rf, m_mem.rw, m_mem.data, m_mem.valid}));
         check("mem_mm",  32'(mem_mm),  32'(m_mem.mm));
         check("mem_rd",  32'(mem_rd),  32'(m_mem.rd));
         check("wb_ctl",  32'(wb_ctl),  32'({m_wb.load, m_wb.rf, m_wb.valid}));
         check("wb_rd",   32'(wb_rd),   32'(m_wb.rd));
         check("bubble_cnt",   32'(bubble_cnt),  (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
         check("bubble_cnt_w2", 32'(bubble_cnt2), (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
         check("id_stall", 32'(id_stall),
               32'(!reset && (stall_ext || m_hz(ir, ir_valid, m_ex))));
      end
   end

   // ---------------- stimulus ----------------
   logic pre_stall;

   task automatic cyc(input logic rst, input logic [31:0] w, input logic v,
                      input logic [3:0] f, input logic fl, input logic sx);
      @(negedge clk);
      #1;
      reset = rst; ir = w; ir_valid = v; flags = f; ex_flush = fl; stall_ext = sx;
      #1;
      pre_stall = id_stall;
      @(posedge clk);
      #1;
   endtask

   typedef struct packed {
      logic [31:0] w;
      logic [3:0]  f;
      logic        fl, sx;
   } vec_t;

   vec_t tbl[$] = '{
      '{32'hE3A01005, 4'h0, 1'b0, 1'b0},  // MOV r1,#5
      '{32'hE5C12000, 4'h0, 1'b0, 1'b0},  // STRB r2,[r1]
      '{32'hE7912003, 4'h0, 1'b0, 1'b0},  // LDR r2,[r1,r3]
      '{32'hE0823001, 4'h0, 1'b0, 1'b0},  // ADD r3,r2,r1 (Rn hazard)
      '{32'hE0823001, 4'h0, 1'b0, 1'b0},
      '{32'hE5912000, 4'h0, 1'b0, 1'b0},  // LDR r2,[r1]
      '{32'hE5812000, 4'h0, 1'b0, 1'b0},  // STR r2,[r1] (Rd hazard)
      '{32'hE5812000, 4'h0, 1'b0, 1'b0},
      '{32'hE5910000, 4'h0, 1'b0, 1'b0},  // LDR r0,[r1]
      '{32'hE1A01002, 4'h0, 1'b0, 1'b0},  // MOV r1,r2 (Rn not read)
      '{32'hE5912000, 4'h0, 1'b0, 1'b0},
      '{32'hE1A00002, 4'h0, 1'b0, 1'b0},  // MOV r0,r2 (Rm hazard)
      '{32'hE1A00002, 4'h0, 1'b0, 1'b0},
      '{32'hEA000010, 4'h0, 1'b0, 1'b0},  // B
      '{32'h1A000005, 4'h4, 1'b0, 1'b0},  // BNE, Z=1 fails
      '{32'h1A000005, 4'h0, 1'b0, 1'b0},  // BNE, Z=0 passes
      '{32'hB0812003, 4'h8, 1'b0, 1'b0},  // ADDLT N=1 V=0
      '{32'hC0812003, 4'h4, 1'b0, 1'b0},  // ADDGT Z=1 fails
      '{32'hF0810002, 4'h0, 1'b0, 1'b0},  // NV
      '{32'hEC000000, 4'h0, 1'b0, 1'b0},  // other encoding
      '{32'hE1A00102, 4'h0, 1'b0, 1'b0},  // MOV r0,r2,LSL#2
      '{32'hE5912000, 4'h0, 1'b0, 1'b0},
      '{32'hE0823001, 4'h0, 1'b0, 1'b1},  // freeze over a hazard
      '{32'hE0823001, 4'h0, 1'b1, 1'b1},  // freeze beats flush
      '{32'hE0823001, 4'h0, 1'b0, 1'b0},
      '{32'hE0823001, 4'h0, 1'b0, 1'b0},
      '{32'h80812003, 4'h2, 1'b0, 1'b0},  // ADDHI C=1 Z=0
      '{32'h90812003, 4'h2, 1'b0, 1'b0},  // ADDLS fails
      '{32'h40812003, 4'h1, 1'b0, 1'b0}   // ADDVS
   };

   initial begin
      reset = 1'b1; ir = 32'hE0810002; ir_valid = 1'b1; flags = 4'h0;
      ex_flush = 1'b0; stall_ext = 1'b0;

      cyc(1, 32'hE0810002, 1, 4'h0, 0, 0);
      cyc(1, 32'hE0810002, 1, 4'h0, 0, 0);
      check("lit_rst_ex_ctl",  32'(ex_ctl), 32'h0);
      check("lit_rst_mem_ctl", 32'(mem_ctl), 32'h0);
      check("lit_rst_wb_ctl",  32'(wb_ctl), 32'h0);
      check("lit_rst_cnt",     32'(bubble_cnt), 32'h0);
      check("lit_rst_stall",   32'(pre_stall), 32'h0);

      cyc(0, 32'hE0810002, 1, 4'h0, 0, 0);               // ADD r0,r1,r2
      check("lit_add_ex_op",  32'(ex_op), 32'h4);
      check("lit_add_ex_sm",  32'(ex_sm), 32'h1);
      check("lit_add_ex_ctl", 32'(ex_ctl), 32'h11);
      cyc(0, 32'h0, 0, 4'h0, 0, 0);
      check("lit_add_mem_ctl", 32'(mem_ctl), 32'h09);
      cyc(0, 32'h0, 0, 4'h0, 0, 0);
      check("lit_add_wb_ctl", 32'(wb_ctl), 32'h3);
      check("lit_add_wb_rd",  32'(wb_rd), 32'h0);

      cyc(0, 32'hE5913000, 1, 4'h0, 0, 0);               // LDR r3,[r1]
      check("lit_ldr_ex_ctl", 32'(ex_ctl), 32'h57);
      cyc(0, 32'hE0834005, 1, 4'h0, 0, 0);               // ADD r4,r3,r5
      check("lit_lu_stall",  32'(pre_stall), 32'h1);
      check("lit_lu_ex_ctl", 32'(ex_ctl), 32'h0);
      check("lit_lu_cnt",    32'(bubble_cnt), 32'h1);
      cyc(0, 32'hE0834005, 1, 4'h0, 0, 0);
      check("lit_lu_release", 32'(pre_stall), 32'h0);
      check("lit_lu_ex_rd",   32'(ex_rd), 32'h4);

      cyc(0, 32'h00810002, 1, 4'h0, 0, 0);               // ADDEQ, Z=0
      check("lit_eq_fail_valid", 32'(ex_ctl[0]), 32'h0);
      check("lit_eq_fail_cnt",   32'(bubble_cnt), 32'h2);
      cyc(0, 32'h00810002, 1, 4'h4, 0, 0);               // ADDEQ, Z=1
      check("lit_eq_pass_op", 32'(ex_op), 32'h4);

      cyc(0, 32'hE5913000, 1, 4'h0, 0, 0);
      cyc(0, 32'hE0834005, 1, 4'h0, 1, 0);               // flush + load-use together
      check("lit_fs_stall",   32'(pre_stall), 32'h1);
      check("lit_fs_ex_ctl",  32'(ex_ctl), 32'h0);
      check("lit_fs_mem_ctl", 32'(mem_ctl), 32'h1B);
      check("lit_fs_cnt",     32'(bubble_cnt), 32'h3);

      cyc(0, 32'hE0434005, 1, 4'h0, 0, 0);               // SUB r4,r3,r5
      check("lit_sub_ex_op", 32'(ex_op), 32'h2);
      for (int unsigned k = 0; k < 3; k++) begin
         cyc(0, 32'hE0810002, 1, 4'h0, 0, 1);
         check("lit_frz_stall",   32'(pre_stall), 32'h1);
         check("lit_frz_ex_ctl",  32'(ex_ctl), 32'h11);
         check("lit_frz_ex_op",   32'(ex_op), 32'h2);
         check("lit_frz_mem_ctl", 32'(mem_ctl), 32'h0);
         check("lit_frz_wb_ctl",  32'(wb_ctl), 32'h7);
         check("lit_frz_cnt",     32'(bubble_cnt), 32'h3);
      end
      cyc(0, 32'h0, 0, 4'h0, 0, 0);
      check("lit_thaw_mem_ctl", 32'(mem_ctl), 32'h09);
      cyc(0, 32'h00810002, 1, 4'h0, 0, 0);
      check("lit_sat_cnt16", 32'(bubble_cnt), 32'h4);
      check("lit_sat_cnt2",  32'(bubble_cnt2), 32'h3);

      foreach (tbl[i]) cyc(0, tbl[i].w, 1, tbl[i].f, tbl[i].fl, tbl[i].sx);

      cyc(1, 32'hE5913000, 1, 4'h0, 1, 0);               // reset mid-stream
      check("lit_rst2_ex_ctl",  32'(ex_ctl), 32'h0);
      check("lit_rst2_mem_ctl", 32'(mem_ctl), 32'h0);
      check("lit_rst2_wb_ctl",  32'(wb_ctl), 32'h0);
      check("lit_rst2_cnt",     32'(bubble_cnt), 32'h0);
      cyc(0, 32'h0, 0, 4'h0, 0, 0);

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
